// File: rtl/border_pkg.sv
// rtl/border_pkg.sv - shared defaults, pixel type and FSM states for the line window buffer
// Purpose: frame geometry defaults, 8-bit grey pixel type and the window FSM
//          state encoding, shared by row_assembler and line_window_buffer.
// Ports:   none (package).
package border_pkg;

  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 240;

  typedef logic [7:0] pixel_t;

  // IDLE: waiting for row 0; PRIME: row 0 held, waiting for row 1;
  // STREAM: one window per incoming row; FLUSH: emit the zero-padded last window.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;

endpackage

// File: rtl/row_assembler.sv
// rtl/row_assembler.sv - collects raster pixels into one complete image row
// Purpose: writes accepted pixels into asm_row[col], raises asm_full when the
//          row is complete but cannot be shifted out, and presents the row
//          (including a last pixel accepted this very cycle) to the window stage.
// Ports:   clk, rst_n     - clock, asynchronous active-low reset
//          pix_in/pix_valid/pix_ready - pixel input handshake
//          shift          - window stage takes the row this cycle
//          row_done       - a complete row is available this cycle
//          row_data       - WIDTH pixels of the complete row
module row_assembler
  import border_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       shift,
  output logic       row_done,
  output logic [7:0] row_data [WIDTH]
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

  pixel_t        asm_row [WIDTH];
  logic [CW-1:0] col;
  logic          asm_full;
  logic          accept;
  logic          accept_last;

  assign pix_ready   = !asm_full;
  assign accept      = pix_valid && pix_ready;
  assign accept_last = accept && (col == LAST_COL);
  assign row_done    = asm_full || accept_last;

  // The last pixel bypasses the storage so the row can shift out in the
  // same cycle that pixel is accepted.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      row_data[i] = (accept_last && (i == WIDTH - 1)) ? pix_in : asm_row[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      asm_full <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        asm_row[i] <= '0;
      end
    end else begin
      if (accept) begin
        asm_row[col] <= pix_in;
        col          <= (col == LAST_COL) ? '0 : col + 1'b1;
      end
      if (shift) begin
        asm_full <= 1'b0;
      end else if (accept_last) begin
        asm_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - three-row sliding window over a raster pixel stream
// Purpose: buffers image rows and presents a top/mid/bot window per image row,
//          zero-padded above row 0 and below row HEIGHT-1, with a valid/ready
//          handshake towards the minimum/border stage.
// Ports:   clk, rst_n                  - clock, asynchronous active-low reset
//          pix_in/pix_valid/pix_ready  - raster pixel input handshake
//          row_top/row_mid/row_bot     - window rows, WIDTH pixels each
//          win_valid/win_ready         - window output handshake
//          win_row                     - image row index of row_mid
//          win_last                    - window is the last row of the frame
module line_window_buffer
  import border_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] row_top [WIDTH],
  output logic [7:0] row_mid [WIDTH],
  output logic [7:0] row_bot [WIDTH],
  output logic       win_valid,
  input  logic       win_ready,
  output logic [7:0] win_row,
  output logic       win_last
);

  if (HEIGHT < 2 || HEIGHT > 256) begin : g_bad_height
    $error("line_window_buffer: HEIGHT must be in 2..256");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("line_window_buffer: WIDTH must be at least 2");
  end

  localparam logic [7:0] LAST_ROW = 8'(HEIGHT - 1);

  state_t     state;
  state_t     state_nx;
  pixel_t     asm_data [WIDTH];
  logic       row_done;
  logic       slot_free;
  logic       asm_shift;
  logic       load_first;
  logic       flush;
  logic       emit;
  logic [7:0] bot_row;   // image row index currently held in row_bot

  assign slot_free = !win_valid || win_ready;

  row_assembler #(
    .WIDTH(WIDTH)
  ) u_row_assembler (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .shift    (asm_shift),
    .row_done (row_done),
    .row_data (asm_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    asm_shift  = 1'b0;
    load_first = 1'b0;
    flush      = 1'b0;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        if (row_done && slot_free) begin
          asm_shift  = 1'b1;
          load_first = 1'b1;
          state_nx   = PRIME;
        end
      end
      PRIME, STREAM: begin
        // The incoming row completes the window centred on the row in bot.
        if (row_done && slot_free) begin
          asm_shift = 1'b1;
          emit      = 1'b1;
          state_nx  = (bot_row + 8'd1 == LAST_ROW) ? FLUSH : STREAM;
        end
      end
      FLUSH: begin
        // Rows of the next frame may already be assembling; they wait for IDLE.
        if (slot_free) begin
          flush    = 1'b1;
          emit     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_last  <= 1'b0;
      bot_row   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        row_top[i] <= '0;
        row_mid[i] <= '0;
        row_bot[i] <= '0;
      end
    end else begin
      if (asm_shift || flush) begin
        for (int i = 0; i < WIDTH; i++) begin
          row_top[i] <= load_first ? '0 : row_mid[i];
          row_mid[i] <= load_first ? '0 : row_bot[i];
          row_bot[i] <= flush ? '0 : asm_data[i];
        end
      end

      if (load_first) begin
        bot_row <= '0;
      end else if (asm_shift) begin
        bot_row <= bot_row + 8'd1;
      end

      if (emit) begin
        win_row  <= bot_row;
        win_last <= (bot_row == LAST_ROW);
      end

      if (emit) begin
        win_valid <= 1'b1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// tb/tb_line_window_buffer.sv - self-checking bench for line_window_buffer
// Purpose: drives a small (4x3) and a default (320x240) instance and checks
//          every window against rows of the accepted pixel stream.
// Ports:   none (top-level bench).
`timescale 1ns/1ps
module tb_line_window_buffer;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int DW = 320;
  localparam int DH = 240;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // small instance
  logic [7:0] s_pix_in;
  logic       s_pix_valid, s_pix_ready;
  logic [7:0] s_top [SW];
  logic [7:0] s_mid [SW];
  logic [7:0] s_bot [SW];
  logic       s_win_valid, s_win_ready, s_win_last;
  logic [7:0] s_win_row;

  // default-size instance
  logic [7:0] d_pix_in;
  logic       d_pix_valid, d_pix_ready;
  logic [7:0] d_top [DW];
  logic [7:0] d_mid [DW];
  logic [7:0] d_bot [DW];
  logic       d_win_valid, d_win_ready, d_win_last;
  logic [7:0] d_win_row;

  line_window_buffer #(.WIDTH(SW), .HEIGHT(SH)) u_small (
    .clk(clk), .rst_n(rst_n), .pix_in(s_pix_in), .pix_valid(s_pix_valid),
    .pix_ready(s_pix_ready), .row_top(s_top), .row_mid(s_mid), .row_bot(s_bot),
    .win_valid(s_win_valid), .win_ready(s_win_ready), .win_row(s_win_row),
    .win_last(s_win_last)
  );

  line_window_buffer u_dflt (
    .clk(clk), .rst_n(rst_n), .pix_in(d_pix_in), .pix_valid(d_pix_valid),
    .pix_ready(d_pix_ready), .row_top(d_top), .row_mid(d_mid), .row_bot(d_bot),
    .win_valid(d_win_valid), .win_ready(d_win_ready), .win_row(d_win_row),
    .win_last(d_win_last)
  );

  // small-instance stimulus and capture
  logic [7:0]  stim [$];
  logic [7:0]  acc_q [$];
  int          acc_cyc [$];
  int          pix_idx;
  logic [31:0] cap_top [$];
  logic [31:0] cap_mid [$];
  logic [31:0] cap_bot [$];
  int          cap_row [$];
  bit          cap_last [$];
  int          cap_cyc [$];
  logic [31:0] cur_top, cur_mid, cur_bot;
  logic [7:0]  cur_row;
  bit          cur_valid, cur_pready;

  // Window k of the accepted stream: frame k/SH, centre row k%SH; d selects
  // the row above (-1), centre (0) or below (+1), zero outside the frame.
  function automatic logic [31:0] model_row(input int k, input int d);
    int          r;
    int          base;
    logic [31:0] v;
    r    = (k % SH) + d;
    base = (k / SH) * SW * SH + r * SW;
    v    = '0;
    if (r < 0 || r >= SH) return 32'h0;
    for (int c = 0; c < SW; c++) begin
      v[31-8*c -: 8] = (base + c < acc_q.size()) ? acc_q[base+c] : 8'hxx;
    end
    return v;
  endfunction

  // Pixel (r,c) of the default-size test image, zero outside the frame.
  function automatic logic [7:0] pdef(input int r, input int c);
    if (r < 0 || r >= DH) return 8'h00;
    return 8'((r * 7 + c * 13 + 1) ^ (r >> 3));
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    s_pix_valid = 1'b0;
    s_pix_in    = 8'h00;
    s_win_ready = 1'b0;
    d_pix_valid = 1'b0;
    d_pix_in    = 8'h00;
    d_win_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stim.delete(); acc_q.delete(); acc_cyc.delete();
    cap_top.delete(); cap_mid.delete(); cap_bot.delete();
    cap_row.delete(); cap_last.delete(); cap_cyc.delete();
    pix_idx   = 0;
    cur_valid = 1'b0;
    @(negedge clk);
  endtask

  // One clock of the small instance: drive at the falling edge, sample 1ns
  // later, record handshakes that the next rising edge will complete.
  task automatic step_small(input bit v, input bit rdy);
    s_pix_valid = v && (pix_idx < stim.size());
    s_pix_in    = (pix_idx < stim.size()) ? stim[pix_idx] : 8'h00;
    s_win_ready = rdy;
    #1;
    cur_top    = {s_top[0], s_top[1], s_top[2], s_top[3]};
    cur_mid    = {s_mid[0], s_mid[1], s_mid[2], s_mid[3]};
    cur_bot    = {s_bot[0], s_bot[1], s_bot[2], s_bot[3]};
    cur_row    = s_win_row;
    cur_valid  = s_win_valid;
    cur_pready = s_pix_ready;
    if (s_pix_valid && s_pix_ready) begin
      acc_q.push_back(s_pix_in);
      acc_cyc.push_back(cyc);
      pix_idx++;
    end
    if (s_win_valid && s_win_ready) begin
      cap_top.push_back(cur_top);
      cap_mid.push_back(cur_mid);
      cap_bot.push_back(cur_bot);
      cap_row.push_back(int'(s_win_row));
      cap_last.push_back(s_win_last);
      cap_cyc.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int nz;
    do_reset();
    nz = 0;
    for (int i = 0; i < SW; i++) if (s_top[i] !== 0 || s_mid[i] !== 0 || s_bot[i] !== 0) nz++;
    checks++; if (s_pix_ready !== 1'b1) begin failures++; $display("FAIL reset_pix_ready got=%b exp=1", s_pix_ready); end
    checks++; if (s_win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid got=%b exp=0", s_win_valid); end
    checks++; if (s_win_row !== 8'h00) begin failures++; $display("FAIL reset_win_row got=%h exp=00", s_win_row); end
    checks++; if (s_win_last !== 1'b0) begin failures++; $display("FAIL reset_win_last got=%b exp=0", s_win_last); end
    checks++; if (nz != 0) begin failures++; $display("FAIL reset_rows nonzero_pixels=%0d exp=0", nz); end
    checks++; if (d_pix_ready !== 1'b1 || d_win_valid !== 1'b0) begin failures++; $display("FAIL reset_dflt ready=%b valid=%b exp 1/0", d_pix_ready, d_win_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 1; i <= 12; i++) stim.push_back(8'(i));
    for (int n = 0; n < 60 && cap_top.size() < 3; n++) step_small(1'b1, 1'b1);
    repeat (10) step_small(1'b1, 1'b1);
    checks++; if (cap_top.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", cap_top.size()); end
    if (cap_top.size() >= 3) begin
      checks++; if (cap_top[0] !== 32'h0) begin failures++; $display("FAIL basic_w0_top got=%h exp=00000000", cap_top[0]); end
      checks++; if (cap_mid[0] !== 32'h01020304) begin failures++; $display("FAIL basic_w0_mid got=%h exp=01020304", cap_mid[0]); end
      checks++; if (cap_bot[0] !== 32'h05060708) begin failures++; $display("FAIL basic_w0_bot got=%h exp=05060708", cap_bot[0]); end
      checks++; if (cap_bot[2] !== 32'h0 || cap_last[2] !== 1'b1) begin failures++; $display("FAIL basic_w2 bot=%h last=%b exp 00000000/1", cap_bot[2], cap_last[2]); end
      checks++; if (cap_cyc[0] != acc_cyc[7] + 1) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", cap_cyc[0], acc_cyc[7] + 1); end
      checks++; if (cap_cyc[1] != acc_cyc[11] + 1) begin failures++; $display("FAIL basic_latency_w1 got=%0d exp=%0d", cap_cyc[1], acc_cyc[11] + 1); end
      for (int k = 0; k < cap_top.size(); k++) begin
        checks++;
        if (cap_top[k] !== model_row(k, -1) || cap_mid[k] !== model_row(k, 0) || cap_bot[k] !== model_row(k, 1) ||
            cap_row[k] != k % SH || cap_last[k] != (k % SH == SH - 1)) begin
          failures++;
          $display("FAIL basic_window[%0d] got %h/%h/%h row=%0d last=%b exp %h/%h/%h row=%0d", k, cap_top[k], cap_mid[k],
                   cap_bot[k], cap_row[k], cap_last[k], model_row(k, -1), model_row(k, 0), model_row(k, 1), k % SH);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] snap_top, snap_mid, snap_bot;
    logic [7:0]  snap_row;
    int          n, idx_before, unstable, ready_high;
    do_reset();
    for (int i = 0; i < 24; i++) stim.push_back(8'($urandom));
    n = 0;
    while (!cur_valid && n < 50) begin step_small(1'b1, 1'b0); n++; end
    checks++; if (!cur_valid) begin failures++; $display("FAIL stall_w0_seen got=0 exp=1"); end
    snap_top = cur_top; snap_mid = cur_mid; snap_bot = cur_bot; snap_row = cur_row;
    unstable = 0; ready_high = 0;
    for (int i = 0; i < 1000; i++) begin
      idx_before = pix_idx;
      step_small(1'b1, 1'b0);
      if (!cur_valid || cur_top !== snap_top || cur_mid !== snap_mid || cur_bot !== snap_bot || cur_row !== snap_row) unstable++;
      if (idx_before >= 12 && cur_pready) ready_high++;
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL stall_stable bad_cycles=%0d exp=0", unstable); end
    checks++; if (ready_high != 0) begin failures++; $display("FAIL stall_pix_ready high_cycles=%0d exp=0", ready_high); end
    checks++; if (pix_idx != 12) begin failures++; $display("FAIL stall_accepted got=%0d exp=12", pix_idx); end
    for (n = 0; n < 300 && (cap_top.size() < 6 || pix_idx < 24); n++) step_small(1'b1, 1'b1);
    checks++; if (cap_top.size() != 6 || pix_idx != 24) begin failures++; $display("FAIL stall_release windows=%0d pixels=%0d exp 6/24", cap_top.size(), pix_idx); end
    for (int k = 0; k < cap_top.size(); k++) begin
      checks++;
      if (cap_top[k] !== model_row(k, -1) || cap_mid[k] !== model_row(k, 0) || cap_bot[k] !== model_row(k, 1) ||
          cap_row[k] != k % SH || cap_last[k] != (k % SH == SH - 1)) begin
        failures++;
        $display("FAIL stall_window[%0d] got %h/%h/%h row=%0d last=%b exp %h/%h/%h row=%0d", k, cap_top[k], cap_mid[k],
                 cap_bot[k], cap_row[k], cap_last[k], model_row(k, -1), model_row(k, 0), model_row(k, 1), k % SH);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 24; i++) stim.push_back(8'($urandom_range(1, 255)));
    for (int n = 0; n < 200 && cap_top.size() < 6; n++) step_small(1'b1, 1'b1);
    checks++; if (cap_top.size() != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", cap_top.size()); end
    checks++; if (acc_cyc.size() != 24 || acc_cyc[23] - acc_cyc[0] != 23) begin failures++; $display("FAIL b2b_no_gap accepted=%0d exp=24 contiguous", acc_cyc.size()); end
    if (cap_top.size() == 6) begin
      checks++; if (cap_top[3] !== 32'h0 || cap_bot[2] !== 32'h0) begin failures++; $display("FAIL b2b_padding f2w0_top=%h f1w2_bot=%h exp 0/0", cap_top[3], cap_bot[2]); end
    end
    for (int k = 0; k < cap_top.size(); k++) begin
      checks++;
      if (cap_top[k] !== model_row(k, -1) || cap_mid[k] !== model_row(k, 0) || cap_bot[k] !== model_row(k, 1) ||
          cap_row[k] != k % SH || cap_last[k] != (k % SH == SH - 1)) begin
        failures++;
        $display("FAIL b2b_window[%0d] got %h/%h/%h row=%0d last=%b exp %h/%h/%h row=%0d", k, cap_top[k], cap_mid[k],
                 cap_bot[k], cap_row[k], cap_last[k], model_row(k, -1), model_row(k, 0), model_row(k, 1), k % SH);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3 * SW * SH; i++) stim.push_back(8'($urandom));
    for (int n = 0; n < 3000 && (cap_top.size() < 3 * SH || pix_idx < 3 * SW * SH); n++)
      step_small(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (20) step_small(1'b1, 1'b1);
    checks++; if (acc_q.size() != 3 * SW * SH) begin failures++; $display("FAIL rand_pixels got=%0d exp=%0d", acc_q.size(), 3 * SW * SH); end
    checks++; if (cap_top.size() != 3 * SH) begin failures++; $display("FAIL rand_windows got=%0d exp=%0d", cap_top.size(), 3 * SH); end
    for (int k = 0; k < cap_top.size(); k++) begin
      checks++;
      if (cap_top[k] !== model_row(k, -1) || cap_mid[k] !== model_row(k, 0) || cap_bot[k] !== model_row(k, 1) ||
          cap_row[k] != k % SH || cap_last[k] != (k % SH == SH - 1)) begin
        failures++;
        $display("FAIL rand_window[%0d] got %h/%h/%h row=%0d last=%b exp %h/%h/%h row=%0d", k, cap_top[k], cap_mid[k],
                 cap_bot[k], cap_row[k], cap_last[k], model_row(k, -1), model_row(k, 0), model_row(k, 1), k % SH);
      end
    end
  endtask

  task automatic test_default_stream();
    int di, nwin, prev, w0_cyc, w0_exp;
    int gap_bad, row_bad, last_bad, data_bad, stall;
    do_reset();
    di = 0; nwin = 0; prev = 0; w0_cyc = -1; w0_exp = -2;
    gap_bad = 0; row_bad = 0; last_bad = 0; data_bad = 0; stall = 0;
    d_win_ready = 1'b1;
    for (int n = 0; n < DW * DH + 2000 && (di < DW * DH || nwin < DH); n++) begin
      d_pix_valid = (di < DW * DH);
      d_pix_in    = pdef(di / DW, di % DW);
      #1;
      if (d_pix_valid && !d_pix_ready) stall++;
      if (d_win_valid) begin
        if (d_win_row !== 8'(nwin)) row_bad++;
        if (d_win_last !== (nwin == DH - 1)) last_bad++;
        if (nwin >= 1 && nwin <= DH - 2 && cyc - prev != DW) gap_bad++;
        if (nwin == 0) w0_cyc = cyc;
        for (int j = 0; j < 3; j++) begin
          int c;
          c = (j == 0) ? 0 : (j == 1) ? DW - 1 : (nwin * 37) % DW;
          if (d_top[c] !== pdef(nwin - 1, c) || d_mid[c] !== pdef(nwin, c) || d_bot[c] !== pdef(nwin + 1, c)) data_bad++;
        end
        prev = cyc;
        nwin++;
      end
      if (d_pix_valid && d_pix_ready) begin
        if (di == 2 * DW - 1) w0_exp = cyc + 1;
        di++;
      end
      @(negedge clk);
    end
    d_pix_valid = 1'b0;
    checks++; if (nwin != DH) begin failures++; $display("FAIL dflt_windows got=%0d exp=%0d", nwin, DH); end
    checks++; if (di != DW * DH) begin failures++; $display("FAIL dflt_pixels got=%0d exp=%0d", di, DW * DH); end
    checks++; if (stall != 0) begin failures++; $display("FAIL dflt_stalls got=%0d exp=0", stall); end
    checks++; if (row_bad != 0 || last_bad != 0) begin failures++; $display("FAIL dflt_row_order row_bad=%0d last_bad=%0d exp 0/0", row_bad, last_bad); end
    checks++; if (gap_bad != 0) begin failures++; $display("FAIL dflt_spacing bad_gaps=%0d exp=0", gap_bad); end
    checks++; if (data_bad != 0) begin failures++; $display("FAIL dflt_data bad_pixels=%0d exp=0", data_bad); end
    checks++; if (w0_cyc != w0_exp) begin failures++; $display("FAIL dflt_latency got=%0d exp=%0d", w0_cyc, w0_exp); end
  endtask

  task automatic test_reset_mid_frame();
    int di, nz, bad, seen;
    do_reset();
    di = 0;
    d_win_ready = 1'b1;
    for (int n = 0; n < 1000 && di < 500; n++) begin
      d_pix_valid = 1'b1;
      d_pix_in    = pdef(di / DW, di % DW);
      #1;
      if (d_pix_ready) di++;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < DW; i++) if (d_top[i] !== 0 || d_mid[i] !== 0 || d_bot[i] !== 0) nz++;
    checks++; if (nz != 0) begin failures++; $display("FAIL rstmid_rows nonzero_pixels=%0d exp=0", nz); end
    checks++; if (d_win_valid !== 1'b0 || d_win_row !== 8'h00 || d_win_last !== 1'b0 || d_pix_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_outputs valid=%b row=%h last=%b ready=%b exp 0/00/0/1", d_win_valid, d_win_row, d_win_last, d_pix_ready);
    end
    d_pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    di = 0; seen = 0; bad = 0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      d_pix_valid = 1'b1;
      d_pix_in    = pdef(di / DW, di % DW) ^ 8'hA5;
      #1;
      if (d_win_valid) begin
        seen = 1;
        if (d_win_row !== 8'h00) bad++;
        for (int c = 0; c < DW; c++) begin
          if (d_top[c] !== 8'h00 || d_mid[c] !== (pdef(0, c) ^ 8'hA5) || d_bot[c] !== (pdef(1, c) ^ 8'hA5)) bad++;
        end
      end
      if (d_pix_ready) di++;
      @(negedge clk);
    end
    d_pix_valid = 1'b0;
    checks++; if (seen != 1) begin failures++; $display("FAIL rstmid_w0_seen got=%0d exp=1", seen); end
    checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_w0_data bad=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_random();
    test_default_stream();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
